// File: rtl/rom_burst_reader_if.sv
// Bundle of the three ports around rom_burst_reader:
//   request  : req_valid/req_ready handshake carrying a word address and beats-minus-one length
//   response : resp_valid/resp_ready handshake carrying a ROM word and an end-of-burst flag
//   rom      : me/oe/address out to the mask-ROM macro, q back (one cycle after me)
// slave  = reader side (accepts requests, returns beats, drives the ROM)
// master = requester side (issues requests, consumes beats, models the ROM)
interface rom_burst_reader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_last;
  logic                  rom_me;
  logic                  rom_oe;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_q;

  modport slave (
    input  req_valid, req_addr, req_len, resp_ready, rom_q,
    output req_ready, resp_valid, resp_data, resp_last, rom_me, rom_oe, rom_address
  );

  modport master (
    output req_valid, req_addr, req_len, resp_ready, rom_q,
    input  req_ready, resp_valid, resp_data, resp_last, rom_me, rom_oe, rom_address
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst read initiator for the synchronous mask-ROM macro (1-cycle registered read).
// Takes word-address bursts on the request port, walks the ROM one word per cycle,
// captures rom_q into a small response FIFO and returns beats with a last flag.
// Ports:
//   clock    single clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   bus      rom_burst_reader_if.slave (request, response and ROM signal groups)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | req_ready high, waiting for a burst request
// BURST | issuing ROM reads, one per cycle while FIFO credit allows
module rom_burst_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  rom_burst_reader_if.slave    bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic                  last_mem_q [FIFO_DEPTH];

  logic                  req_ready;
  logic                  req_fire;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  resp_valid;
  logic [CNT_W:0]        occupancy;

  assign push = inflight_q;
  assign pop  = resp_valid & bus.resp_ready;

  // Entries the FIFO will hold once the word already in the ROM pipe lands;
  // a new read is only issued when there is room for it as well.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign req_fire  = bus.req_valid & req_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = BURST;
      BURST:   if (issue && (remain_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // req_ready is gated by reset_n so it drops immediately on reset assertion.
  always_comb begin
    req_ready = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE:    req_ready = reset_n;
      BURST:   issue     = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
      default: ;
    endcase
  end

  // ---------------- burst address / length tracking ----------------
  always_comb begin
    cur_addr_d      = cur_addr_q;
    remain_d        = remain_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remain_q == '0);
    if (req_fire) begin
      cur_addr_d = bus.req_addr;
      remain_d   = bus.req_len;
    end else if (issue) begin
      cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
      remain_d   = remain_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q      <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      cur_addr_q      <= cur_addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // ---------------- response FIFO ----------------
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.rom_q;
      last_mem_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assert property (@(posedge clock) disable iff (!reset_n)
                   !(push && (count_q == CNT_W'(FIFO_DEPTH))));

  // ---------------- outputs ----------------
  assign resp_valid      = (count_q != '0);
  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_data   = resp_valid ? data_mem_q[rd_ptr_q] : '0;
  assign bus.resp_last   = resp_valid & last_mem_q[rd_ptr_q];
  assign bus.rom_me      = issue;
  assign bus.rom_oe      = inflight_q;
  assign bus.rom_address = cur_addr_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rom_burst_reader_if bus ();

  rom_burst_reader dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ROM model: rom[i] = 0xA500_0000 | i, registered read, q driven while oe
  logic [31:0] rom_q_reg;
  always @(posedge clock)
    if (bus.rom_me) rom_q_reg <= 32'hA500_0000 | {21'd0, bus.rom_address};
  assign bus.rom_q = bus.rom_oe ? rom_q_reg : 32'h0;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  logic  me_prev = 1'b0;
  logic  hold_prev = 1'b0;
  logic [33:0] held;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset_n) begin
      me_prev   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      checks++;
      assert (bus.rom_oe === me_prev) else begin
        errors++;
        $error("FAIL rom_oe observed=%0b expected=%0b", bus.rom_oe, me_prev);
      end
      if (hold_prev) begin
        checks++;
        assert ({bus.resp_valid, bus.resp_last, bus.resp_data} === held) else begin
          errors++;
          $error("FAIL resp_hold observed=%0h expected=%0h",
                 {bus.resp_valid, bus.resp_last, bus.resp_data}, held);
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", bus.resp_data);
        end
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          checks++;
          assert (bus.resp_data === e.data) else begin
            errors++;
            $error("FAIL resp_data observed=%0h expected=%0h", bus.resp_data, e.data);
          end
          checks++;
          assert (bus.resp_last === e.last) else begin
            errors++;
            $error("FAIL resp_last observed=%0b expected=%0b", bus.resp_last, e.last);
          end
          beats_seen++;
        end
      end
      hold_prev = bus.resp_valid && !bus.resp_ready;
      held      = {bus.resp_valid, bus.resp_last, bus.resp_data};
      me_prev   = bus.rom_me;
    end
  end

  // Present a request, push its expected beats, return at accept edge + 1
  task automatic send_req(input logic [10:0] a, input logic [3:0] l, output int acc);
    bit got;
    got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("req_accept", {31'd0, got}, 32'd1);
    for (int i = 0; i <= int'(l); i++) begin
      beat_t e;
      logic [10:0] ad;
      ad     = a + 11'(i);
      e.data = 32'hA500_0000 | {21'd0, ad};
      e.last = (i == int'(l));
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input bit bp, input string tag);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      @(posedge clock);
      #1;
      if (bp) bus.resp_ready = 1'($urandom_range(0, 1));
    end
    bus.resp_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  {31'd0, bus.req_ready},  32'd0);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_resp_last"},  {31'd0, bus.resp_last},  32'd0);
    chk({tag, "_resp_data"},  bus.resp_data,           32'd0);
    chk({tag, "_rom_me"},     {31'd0, bus.rom_me},     32'd0);
    chk({tag, "_rom_oe"},     {31'd0, bus.rom_oe},     32'd0);
    chk({tag, "_rom_addr"},   {21'd0, bus.rom_address}, 32'd0);
  endtask

  initial begin
    int acc_a, acc_b, n, run, base;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.resp_ready = 1'b0;

    // reset state
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // 1: single beat, latency
    bus.resp_ready = 1'b1;
    send_req(11'h010, 4'd0, acc_a);
    chk("t1_me_e0",    {31'd0, bus.rom_me},      32'd1);
    chk("t1_addr_e0",  {21'd0, bus.rom_address}, 32'h010);
    chk("t1_ready_e0", {31'd0, bus.req_ready},   32'd0);
    @(posedge clock);
    #1;
    chk("t1_me_e1",    {31'd0, bus.rom_me},     32'd0);
    chk("t1_oe_e1",    {31'd0, bus.rom_oe},     32'd1);
    chk("t1_valid_e1", {31'd0, bus.resp_valid}, 32'd0);
    chk("t1_ready_e1", {31'd0, bus.req_ready},  32'd1);
    @(posedge clock);
    #1;
    chk("t1_valid_e2", {31'd0, bus.resp_valid}, 32'd1);
    chk("t1_data_e2",  bus.resp_data,           32'hA500_0010);
    chk("t1_last_e2",  {31'd0, bus.resp_last},  32'd1);
    drain(1'b0, "t1_drain");

    // 2: address wrap 0x7F8..0x007
    send_req(11'h7F8, 4'd15, acc_a);
    drain(1'b0, "t2_drain");

    // 3: throughput, 16 consecutive valid cycles
    send_req(11'h100, 4'd15, acc_a);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    run = 0;
    while (bus.resp_valid && run < 40) begin
      run++;
      @(negedge clock);
    end
    chk("t3_run_len", run, 32'd16);
    drain(1'b0, "t3_drain");

    // 4: random backpressure
    bus.resp_ready = 1'b0;
    send_req(11'h300, 4'd15, acc_a);
    drain(1'b1, "t4_drain");

    // 5: back-to-back requests
    bus.resp_ready = 1'b1;
    send_req(11'h020, 4'd3, acc_a);
    send_req(11'h040, 4'd1, acc_b);
    chk("t5_accept_gap", acc_b - acc_a, 32'd5);
    drain(1'b0, "t5_drain");

    // 6: reset during beat 5 of 16
    base = beats_seen;
    send_req(11'h200, 4'd15, acc_a);
    n = 0;
    while (beats_seen < base + 4 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("t6_beats_before_rst", beats_seen - base, 32'd4);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_ready_after", {31'd0, bus.req_ready}, 32'd1);
    base = beats_seen;
    send_req(11'h005, 4'd0, acc_a);
    drain(1'b0, "t6_drain");
    chk("t6_beat_count", beats_seen - base, 32'd1);
    chk("t6_idle_valid", {31'd0, bus.resp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
